// File: rtl/path_test_pkg.sv
// Shared types for the ISCAS85 path test sequencer: FSM states, buffered
// vector entries and the settle counter width helper.
package path_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic stim;
        logic exp;
        logic mask;
    } vec_entry_t;

    // The counter is loaded with settle-1, so it needs clog2(settle) bits (min 1).
    function automatic int settle_cnt_w(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/path_test_vec_mem.sv
// Vector buffer: DEPTH x {stim, exp, mask} register file, one write port and
// one asynchronous read port. Entry validity is tracked outside via vec_count.
module path_test_vec_mem
    import path_test_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDXW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IDXW-1:0] waddr,
    input  vec_entry_t      wdata,
    input  logic [IDXW-1:0] raddr,
    output vec_entry_t      rdata
);

    vec_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/path_test_sequencer.sv
// Applies buffered stimulus vectors to a single-bit combinational path, waits
// a settle time, compares the path output and accumulates pass/fail results.
module path_test_sequencer
    import path_test_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            load_stim,
    input  logic            load_exp,
    input  logic            load_mask,
    input  logic            clear,
    input  logic            start,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IDXW:0]   fail_count,
    output logic [IDXW-1:0] first_fail_idx,
    output logic [IDXW:0]   vec_count,
    output logic            cut_in,
    input  logic            cut_out
);

    localparam int CNTW = settle_cnt_w(SETTLE);

    state_t          state, state_next;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] settle_cnt;
    vec_entry_t      wr_entry, rd_entry;
    logic            idle_like, load_fire, last_vec, mismatch;

    path_test_vec_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (load_fire),
        .waddr (vec_count[IDXW-1:0]),
        .wdata (wr_entry),
        .raddr (idx),
        .rdata (rd_entry)
    );

    always_comb begin
        idle_like  = (state == ST_IDLE) || (state == ST_DONE);
        load_ready = idle_like && (vec_count < (IDXW+1)'(DEPTH));
        // clear outranks a same-cycle load, which is then dropped.
        load_fire  = load_valid && load_ready && !clear;
        wr_entry   = '{stim: load_stim, exp: load_exp, mask: load_mask};
        last_vec   = ({1'b0, idx} == (vec_count - (IDXW+1)'(1)));
        mismatch   = !rd_entry.mask && (cut_out != rd_entry.exp);
        busy       = (state == ST_APPLY) || (state == ST_SETTLE) || (state == ST_SAMPLE);
        done       = (state == ST_DONE);
        pass       = done && (fail_count == '0);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (clear) begin
                    state_next = ST_IDLE;
                end else if (start) begin
                    state_next = ((vec_count != '0) || load_fire) ? ST_APPLY : ST_DONE;
                end
            end
            ST_APPLY:  state_next = abort ? ST_IDLE : ST_SETTLE;
            ST_SETTLE: state_next = abort ? ST_IDLE : ((settle_cnt == '0) ? ST_SAMPLE : ST_SETTLE);
            ST_SAMPLE: state_next = abort ? ST_IDLE : (last_vec ? ST_DONE : ST_APPLY);
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On abort the counters keep their partial values; only cut_in is parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_count      <= '0;
            idx            <= '0;
            settle_cnt     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            cut_in         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (clear) begin
                        vec_count <= '0;
                    end else begin
                        if (load_fire) begin
                            vec_count <= vec_count + (IDXW+1)'(1);
                        end
                        if (start) begin
                            fail_count     <= '0;
                            first_fail_idx <= '0;
                            idx            <= '0;
                        end
                    end
                end
                ST_APPLY: begin
                    cut_in     <= abort ? 1'b0 : rd_entry.stim;
                    settle_cnt <= CNTW'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (abort) begin
                        cut_in <= 1'b0;
                    end else if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNTW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        cut_in <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            fail_count <= fail_count + (IDXW+1)'(1);
                            if (fail_count == '0) begin
                                first_fail_idx <= idx;
                            end
                        end
                        if (last_vec) begin
                            cut_in <= 1'b0;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                end
                default: cut_in <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_path_test_sequencer.sv
// Self-checking bench for path_test_sequencer; the path under test is an inverter
// and results are predicted from a queue-based model of the loaded vectors.
module tb_path_test_sequencer;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;
    localparam int IDXW   = $clog2(DEPTH);
    localparam int LIMIT  = 2000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_valid = 1'b0, load_stim = 1'b0, load_exp = 1'b0, load_mask = 1'b0;
    logic            clear = 1'b0, start = 1'b0, abort = 1'b0;
    logic            load_ready, busy, done, pass, cut_in, cut_out;
    logic [IDXW:0]   fail_count, vec_count;
    logic [IDXW-1:0] first_fail_idx;

    int checks = 0;
    int errors = 0;

    bit m_stim[$];
    bit m_exp[$];
    bit m_mask[$];

    path_test_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_stim      (load_stim),
        .load_exp       (load_exp),
        .load_mask      (load_mask),
        .clear          (clear),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .vec_count      (vec_count),
        .cut_in         (cut_in),
        .cut_out        (cut_out)
    );

    assign cut_out = ~cut_in;

    always #5 clk = ~clk;

    function automatic int model_fails();
        int n = 0;
        foreach (m_stim[i]) if (!m_mask[i] && ((!m_stim[i]) != m_exp[i])) n++;
        return n;
    endfunction

    function automatic int model_first();
        foreach (m_stim[i]) if (!m_mask[i] && ((!m_stim[i]) != m_exp[i])) return i;
        return 0;
    endfunction

    // Inputs change right after a falling edge; outputs are read there too.
    task automatic load_vec(input bit s, input bit e, input bit m);
        load_valid = 1'b1; load_stim = s; load_exp = e; load_mask = m;
        if (m_stim.size() < DEPTH) begin
            m_stim.push_back(s); m_exp.push_back(e); m_mask.push_back(m);
        end
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic clear_buf();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_stim.delete(); m_exp.delete(); m_mask.delete();
    endtask

    task automatic load_inverter_set();
        load_vec(1, 0, 0); load_vec(0, 1, 0); load_vec(1, 0, 0); load_vec(0, 1, 0);
    endtask

    // waited = rising edges after the start edge until done is seen high.
    task automatic run_wait(output int waited, output bit busy_ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_valid = 1'b0;
        waited = 0;
        busy_ok = 1'b1;
        while (!done && waited < LIMIT) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic test_reset();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_load_ready: got %0b expected 1", load_ready); end
        checks++; if ({busy, done, pass, cut_in} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, pass, cut_in}); end
        checks++; if (vec_count !== '0 || fail_count !== '0 || first_fail_idx !== '0) begin errors++; $display("[TB] FAIL reset_counts: got vc=%0d fc=%0d ffi=%0d expected 0", vec_count, fail_count, first_fail_idx); end
    endtask

    task automatic test_inverter_pass();
        int w; bit b;
        clear_buf();
        load_inverter_set();
        checks++; if (vec_count !== 4) begin errors++; $display("[TB] FAIL p1_vec_count: got %0d expected 4", vec_count); end
        run_wait(w, b);
        checks++; if (w != 4 * (SETTLE + 2)) begin errors++; $display("[TB] FAIL p1_latency: got %0d expected %0d", w, 4 * (SETTLE + 2)); end
        checks++; if (!b) begin errors++; $display("[TB] FAIL p1_busy: got 0 during run expected 1"); end
        checks++; if (pass !== 1'b1 || fail_count !== 0) begin errors++; $display("[TB] FAIL p1_result: got pass=%0b fc=%0d expected pass=1 fc=0", pass, fail_count); end
        checks++; if (cut_in !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL p1_done_state: got cut_in=%0b busy=%0b expected 0 0", cut_in, busy); end
    endtask

    task automatic test_mismatch();
        int w; bit b;
        clear_buf();
        load_vec(1, 0, 0); load_vec(0, 1, 0); load_vec(1, 1, 0); load_vec(0, 0, 0);
        run_wait(w, b);
        checks++; if (fail_count !== model_fails()) begin errors++; $display("[TB] FAIL p2_fail_count: got %0d expected %0d", fail_count, model_fails()); end
        checks++; if (first_fail_idx !== model_first()) begin errors++; $display("[TB] FAIL p2_first_fail: got %0d expected %0d", first_fail_idx, model_first()); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL p2_pass: got pass=%0b done=%0b expected 0 1", pass, done); end
    endtask

    task automatic test_back_to_back();
        int w; bit b;
        // Replay of the buffer left by the previous scenario.
        run_wait(w, b);
        checks++; if (fail_count !== model_fails() || first_fail_idx !== model_first()) begin errors++; $display("[TB] FAIL replay_result: got fc=%0d ffi=%0d expected %0d %0d", fail_count, first_fail_idx, model_fails(), model_first()); end
        load_valid = 1'b1; load_stim = 1'b0; load_exp = 1'b0; load_mask = 1'b0;
        m_stim.push_back(0); m_exp.push_back(0); m_mask.push_back(0);
        run_wait(w, b);
        checks++; if (w != 5 * (SETTLE + 2)) begin errors++; $display("[TB] FAIL start_load_latency: got %0d expected %0d", w, 5 * (SETTLE + 2)); end
        checks++; if (fail_count !== model_fails() || vec_count !== 5) begin errors++; $display("[TB] FAIL start_load_result: got fc=%0d vc=%0d expected %0d 5", fail_count, vec_count, model_fails()); end
    endtask

    task automatic test_mask();
        int w; bit b;
        clear_buf();
        load_vec(1, 0, 0); load_vec(0, 0, 1); load_vec(1, 0, 0); load_vec(0, 1, 0);
        run_wait(w, b);
        checks++; if (fail_count !== 0 || pass !== 1'b1) begin errors++; $display("[TB] FAIL mask_result: got fc=%0d pass=%0b expected 0 1", fail_count, pass); end
    endtask

    task automatic test_full_buffer();
        int w; bit b; bit s;
        clear_buf();
        for (int i = 0; i < DEPTH; i++) begin
            s = 1'($urandom);
            load_vec(s, !s, 0);
        end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_load_ready: got %0b expected 0", load_ready); end
        load_vec(1, 1, 0);
        checks++; if (vec_count !== DEPTH) begin errors++; $display("[TB] FAIL full_vec_count: got %0d expected %0d", vec_count, DEPTH); end
        run_wait(w, b);
        checks++; if (w != DEPTH * (SETTLE + 2)) begin errors++; $display("[TB] FAIL full_latency: got %0d expected %0d", w, DEPTH * (SETTLE + 2)); end
        checks++; if (pass !== 1'b1) begin errors++; $display("[TB] FAIL full_pass: got %0b expected 1", pass); end
    endtask

    task automatic test_abort();
        int w; bit b;
        clear_buf();
        load_inverter_set();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * (SETTLE + 2) + 1) @(negedge clk);
        checks++; if (busy !== 1'b1 || cut_in !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre: got busy=%0b cut_in=%0b expected 1 1", busy, cut_in); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if ({busy, done, cut_in} !== 3'b000) begin errors++; $display("[TB] FAIL abort_post: got %b expected 000", {busy, done, cut_in}); end
        checks++; if (vec_count !== 4) begin errors++; $display("[TB] FAIL abort_vec_count: got %0d expected 4", vec_count); end
        run_wait(w, b);
        checks++; if (w != 4 * (SETTLE + 2) || pass !== 1'b1) begin errors++; $display("[TB] FAIL abort_restart: got cyc=%0d pass=%0b expected %0d 1", w, pass, 4 * (SETTLE + 2)); end
    endtask

    task automatic test_clear_priority();
        clear = 1'b1; load_valid = 1'b1; load_stim = 1'b1;
        @(negedge clk);
        clear = 1'b0; load_valid = 1'b0;
        m_stim.delete(); m_exp.delete(); m_mask.delete();
        checks++; if (vec_count !== 0 || done !== 1'b0) begin errors++; $display("[TB] FAIL clear_wins: got vc=%0d done=%0b expected 0 0", vec_count, done); end
    endtask

    task automatic test_empty_start();
        int w; bit b;
        run_wait(w, b);
        checks++; if (w != 0 || done !== 1'b1 || pass !== 1'b1) begin errors++; $display("[TB] FAIL empty_start: got cyc=%0d done=%0b pass=%0b expected 0 1 1", w, done, pass); end
    endtask

    task automatic test_reset_mid_run();
        clear_buf();
        load_vec(1, 1, 0); load_vec(0, 0, 0); load_vec(1, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_stim.delete(); m_exp.delete(); m_mask.delete();
        checks++; if ({load_ready, busy, done, pass, cut_in} !== 5'b10000) begin errors++; $display("[TB] FAIL rst_mid_flags: got %b expected 10000", {load_ready, busy, done, pass, cut_in}); end
        checks++; if (vec_count !== 0 || fail_count !== 0 || first_fail_idx !== 0) begin errors++; $display("[TB] FAIL rst_mid_counts: got vc=%0d fc=%0d ffi=%0d expected 0", vec_count, fail_count, first_fail_idx); end
    endtask

    task automatic test_random();
        int w, n; bit b, s, e, m;
        for (int it = 0; it < 8; it++) begin
            clear_buf();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) begin
                s = 1'($urandom);
                e = ($urandom_range(0, 3) == 0) ? s : !s;
                m = ($urandom_range(0, 3) == 0);
                load_vec(s, e, m);
            end
            run_wait(w, b);
            checks++; if (w != n * (SETTLE + 2)) begin errors++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", it, w, n * (SETTLE + 2)); end
            checks++; if (fail_count !== model_fails() || first_fail_idx !== model_first()) begin errors++; $display("[TB] FAIL rnd%0d_result: got fc=%0d ffi=%0d expected %0d %0d", it, fail_count, first_fail_idx, model_fails(), model_first()); end
            checks++; if (pass !== (model_fails() == 0)) begin errors++; $display("[TB] FAIL rnd%0d_pass: got %0b expected %0b", it, pass, model_fails() == 0); end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_inverter_pass();
        test_mismatch();
        test_back_to_back();
        test_mask();
        test_full_buffer();
        test_abort();
        test_clear_priority();
        test_empty_start();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/path_test_sequencer.md
Name: path_test_sequencer

Overview:
Clocked controller that sequences directed test vectors through a single-input/single-output combinational path extracted from an ISCAS85 benchmark for ATPG path testing. It buffers stimulus/expected/mask triples and applies them one at a time to the path input. After a programmable settle time it samples the path output, compares it with the expected value, and reports pass/fail, fail count and first failing index. The block sits between the ATPG vector source and the gate-level path netlist under test.

Parameters:
DEPTH, 16, vector buffer entries (power of two, >=2)
SETTLE, 2, idle cycles between driving cut_in and sampling cut_out (>=1)
IDXW, $clog2(DEPTH), index width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
load_valid  in  1  vector load request
load_ready  out  1  buffer accepts a vector this cycle
load_stim  in  1  stimulus bit for path input
load_exp  in  1  expected path output
load_mask  in  1  1 = do not compare this vector
clear  in  1  empty the buffer (IDLE/DONE only)
start  in  1  begin a run
abort  in  1  terminate the run
busy  out  1  run in progress
done  out  1  run complete, results valid
pass  out  1  fail_count==0 (valid when done)
fail_count  out  IDXW+1  unmasked mismatches
first_fail_idx  out  IDXW  index of first mismatch (0 if none)
vec_count  out  IDXW+1  vectors buffered
cut_in  out  1  registered drive to path input
cut_out  in  1  path output

Behaviour:
- The single clock is clk. The reset is rst, which is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE, load_ready=1, busy=0, done=0, pass=0, fail_count=0, first_fail_idx=0, vec_count=0, cut_in=0. Reset mid-run discards the buffer.
- States are IDLE, APPLY, SETTLE, SAMPLE, DONE.
- load_ready = (state is IDLE or DONE) and vec_count<DEPTH.
- A load is accepted when load_valid and load_ready are both high. The entry is written at index vec_count, and vec_count is incremented.
- If the buffer is full (vec_count==DEPTH), load_ready=0 and load_valid is ignored.
- clear in IDLE/DONE sets vec_count=0 and goes to IDLE with done=0. clear is ignored while busy. If clear and a load occur in the same cycle, clear wins and the load is dropped.
- start in IDLE/DONE:
  - Clears done, fail_count and first_fail_idx, and sets idx=0.
  - If vec_count>0 after any same-cycle load, go to APPLY. A load in the same cycle as start is included in the run.
  - If vec_count==0, go directly to DONE with pass=1.
- APPLY (1 cycle): cut_in <= stim[idx], settle counter <= SETTLE-1, go to SETTLE. busy=1 in APPLY, SETTLE and SAMPLE.
- SETTLE: decrement the counter and hold cut_in. When the counter reaches 0, go to SAMPLE. Total SETTLE cycles per vector.
- SAMPLE (1 cycle): if mask[idx]==0 and cut_out!=exp[idx], increment fail_count. On the first such mismatch, first_fail_idx <= idx.
  - If idx==vec_count-1, go to DONE.
  - Otherwise idx++ and go to APPLY.
- Per-vector latency is SETTLE+2 cycles. Run length is vec_count*(SETTLE+2) cycles from the start edge to done high.
- DONE:
  - done=1, pass=(fail_count==0), cut_in <= 0.
  - Results and buffer are held until start, clear or rst.
  - Restarting replays the same buffer.
- abort in APPLY/SETTLE/SAMPLE: next state IDLE, cut_in <= 0, done=0. Counters keep partial values, and the buffer is retained. abort in IDLE/DONE has no effect.
- Priority: rst > abort > clear > start > load.
- fail_count cannot exceed DEPTH, so no wrap is possible.

Decomposition:
- Package path_test_pkg holds:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE)
  - vector entry struct {stim, exp, mask}
  - helper constant for SETTLE counter width
- Sub-module path_test_vec_mem is a DEPTH x 3-bit register file with one write port and one asynchronous read port indexed by idx. It has no reset on the storage array; validity is tracked by vec_count.

Test Plan:
1. Bench models the path as an inverter; load 4 vectors stim=1,0,1,0 exp=0,1,0,1 mask=0; start -> done after 16 cycles (SETTLE=2), pass=1, fail_count=0, cut_in=0 in DONE.
2. Same load but exp[2]=1 and exp[3]=0 -> fail_count=2, first_fail_idx=2, pass=0.
3. Load 16 vectors -> load_ready=0 after the 16th accept, a 17th load_valid is ignored, vec_count=16; run -> done after 64 cycles.
4. Mask vector 1 while exp[1] is wrong -> fail_count=0, pass=1.
5. Assert abort in the SETTLE of vector 2 -> next cycle IDLE, busy=0, done=0, cut_in=0; restart -> full run and a correct result.
6. start with an empty buffer -> done=1 and pass=1 on the next cycle. Then assert rst mid-run of a 3-vector run -> all outputs at reset values and vec_count=0.
